// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer with the HI/LO pair: fixed-latency busy window, commit on completion.
// Optional madd/msub accumulate ops (md_op 110/111) are built only when MD_UNIT_MADD_EN is defined.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A1,
  input  logic [31:0] A2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic [63:0] prod_s, prod_u, divs_res, divu_res, res;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [3:0]  cnt_load;
  logic        md_go;

  // Sign-extending to 64 bits makes the truncated unsigned product the signed product.
  assign prod_s = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
  assign prod_u = {32'b0, A1} * {32'b0, A2};

  always_comb begin
    a_mag    = A1[31] ? -A1 : A1;
    b_mag    = A2[31] ? -A2 : A2;
    q_mag    = a_mag / b_mag;
    r_mag    = a_mag % b_mag;
    divs_res = {A1[31] ? -r_mag : r_mag, (A1[31] ^ A2[31]) ? -q_mag : q_mag};
    divu_res = {A1 % A2, A1 / A2};
    // Divide by zero: all-ones quotient, dividend left in HI.
    if (A2 == 32'b0) begin
      divs_res = {A1, 32'hFFFF_FFFF};
      divu_res = {A1, 32'hFFFF_FFFF};
    end
  end

  always_comb begin
    md_go    = 1'b0;
    res      = prod_s;
    cnt_load = 4'(MULT_CYCLES - 1);
    case (md_op)
      3'b000: begin md_go = 1'b1; res = prod_s; end
      3'b001: begin md_go = 1'b1; res = prod_u; end
      3'b010: begin md_go = 1'b1; res = divs_res; cnt_load = 4'(DIV_CYCLES - 1); end
      3'b011: begin md_go = 1'b1; res = divu_res; cnt_load = 4'(DIV_CYCLES - 1); end
`ifdef MD_UNIT_MADD_EN
      3'b110: begin md_go = 1'b1; res = {hi_q, lo_q} + prod_s; end
      3'b111: begin md_go = 1'b1; res = {hi_q, lo_q} - prod_s; end
`endif
      default: md_go = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (md_go) begin
            pend_d  = res;
            cnt_d   = cnt_load;
            state_d = RUN;
          end else if (md_op == 3'b100) begin
            hi_d = A1;
          end else if (md_op == 3'b101) begin
            lo_d = A1;
          end
        end
      end
      RUN: begin
        // start is deliberately not looked at here; the hazard unit keeps it low.
        if (cnt_q == 4'd0) begin
          {hi_d, lo_d} = pend_q;
          state_d      = IDLE;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed cases plus random ops against an arithmetic reference.
module tb_md_unit_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  md_op;
  logic [31:0] A1, A2;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A1(A1), .A2(A2), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
    int ia, ib, q, r;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [31:0] qq, rr;
    ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ia / ib; r = ia % ib; qq = q; rr = r;
        return {rr, qq};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd6: return acc + sa * sb;
      3'd7: return acc - sa * sb;
      default: return acc;
    endcase
  endfunction

  function automatic bit is_md(input logic [2:0] op);
`ifdef MD_UNIT_MADD_EN
    return op != 3'd4 && op != 3'd5;
`else
    return op <= 3'd3;
`endif
  endfunction

  // Multi-cycle op; inj>0 fires an mthi request during busy cycle inj, which must be ignored.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    int n;
    logic [63:0] exp;
    n   = (op == 3'd2 || op == 3'd3) ? DC : MC;
    exp = ref_res(op, a, b, {m_hi, m_lo});
    start = 1'b1; md_op = op; A1 = a; A2 = b;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      chk($sformatf("busy op%0d c%0d", op, k), {63'b0, busy}, 64'd1);
      chk($sformatf("done-low op%0d c%0d", op, k), {63'b0, done}, 64'd0);
      chk($sformatf("hilo-hold op%0d c%0d", op, k), {hi, lo}, {m_hi, m_lo});
      if (k == inj) begin
        start = 1'b1; md_op = 3'd4; A1 = 32'h1234; A2 = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    {m_hi, m_lo} = exp;
    chk($sformatf("commit-busy op%0d", op), {63'b0, busy}, 64'd0);
    chk($sformatf("commit-done op%0d", op), {63'b0, done}, 64'd1);
    chk($sformatf("commit-hilo op%0d a=%h b=%h", op, a, b), {hi, lo}, {m_hi, m_lo});
    @(negedge clk);
    chk($sformatf("done-pulse op%0d", op), {63'b0, done}, 64'd0);
  endtask

  // Single-cycle op (mthi/mtlo or reserved): must not raise busy or done.
  task automatic run_fast(input logic [2:0] op, input logic [31:0] a);
    start = 1'b1; md_op = op; A1 = a; A2 = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
    chk($sformatf("fast-busy op%0d", op), {63'b0, busy}, 64'd0);
    chk($sformatf("fast-done op%0d", op), {63'b0, done}, 64'd0);
    chk($sformatf("fast-hilo op%0d", op), {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    if (is_md(op)) run_md(op, a, b, inj);
    else run_fast(op, a);
  endtask

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; A1 = '0; A2 = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset-busy", {63'b0, busy}, 64'd0);
    chk("reset-done", {63'b0, done}, 64'd0);
    chk("reset-hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_md(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mult -2*3", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div -7/2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 3);
    chk("divu ignoring mthi", {hi, lo}, {32'h0000_0001, 32'h7FFF_FFFC});
    run_fast(3'd4, 32'h1234);
    chk("mthi idle", {32'h0, hi}, {32'h0, 32'h1234});
    run_md(3'd2, 32'd5, 32'd0, DC);
    chk("div by zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div overflow", {hi, lo}, {32'h0, 32'h8000_0000});

    // Reset during RUN aborts the op and clears HI/LO with no done pulse.
    start = 1'b1; md_op = 3'd1; A1 = 32'hFFFF_FFFF; A2 = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort-busy", {63'b0, busy}, 64'd0);
    chk("abort-done", {63'b0, done}, 64'd0);
    chk("abort-hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    chk("abort-no-done", {63'b0, done}, 64'd0);
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});

`ifdef MD_UNIT_MADD_EN
    run_fast(3'd5, 32'd10);
    run_fast(3'd4, 32'd0);
    run_md(3'd6, 32'd3, 32'd4, 0);
    chk("madd", {hi, lo}, {32'd0, 32'd22});
    run_md(3'd7, 32'd5, 32'd5, 0);
    chk("msub", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
    run_fast(3'd6, 32'd3);
    chk("reserved 110", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    run_fast(3'd7, 32'd7);
`endif

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_000F;
      do_op(op, a, b, $urandom_range(0, MC));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
